mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Memory-stage bus controller sitting directly downstream of the address decoder. It consumes the decoder's `cs` (0 = internal memory, 1 = external memory) together with the CPU's memory request. It steers each access either to the on-chip synchronous RAM or to the external memory over a req/ack handshake, and stalls the CPU until the access completes. External accesses that never receive an ack are terminated by a timeout that flags a bus error.

## Interface
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, address width.
- `TIMEOUT`, 255, maximum number of cycles `ext_req` stays high without an ack before the access aborts; minimum 1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs`  in  1  from address decoder: 0 = internal, 1 = external; sampled only in IDLE.
- `mem_rd`  in  1  CPU read request, held until stall drops.
- `mem_wr`  in  1  CPU write request, held until stall drops; wins if both are asserted.
- `addr`  in  ADDR_W  CPU address.
- `wdata`  in  DATA_W  CPU write data.
- `rdata`  out  DATA_W  registered read data, valid in DONE.
- `stall`  out  1  CPU hold.
- `bus_err`  out  1  registered; high only in a DONE cycle that ended by timeout.
- `int_en`, `int_we`  out  1  internal RAM enable / write enable.
- `int_addr`  out  ADDR_W  passthrough of `addr`.
- `int_wdata`  out  DATA_W  passthrough of `wdata`.
- `int_rdata`  in  DATA_W  RAM data, 1-cycle read latency.
- `ext_req`  out  1  registered request to external memory.
- `ext_we`  out  1  registered.
- `ext_addr`  out  ADDR_W  registered.
- `ext_wdata`  out  DATA_W  registered.
- `ext_ack`  in  1  external completion.
- `ext_rdata`  in  DATA_W  external read data, valid with `ext_ack`.

## Operation
States: IDLE, INT_RD, EXT, DONE.

- **IDLE, no request:** `stall` = 0, strobes low.
- **IDLE, `mem_wr` & `cs`=0:** `int_en` = `int_we` = 1 combinationally; `stall` = 0; stay IDLE. This is a single-cycle write.
- **IDLE, `mem_rd` & !`mem_wr` & `cs`=0:** `int_en` = 1, `int_we` = 0, `stall` = 1; go to INT_RD.
- **INT_RD:** `stall` = 1; `rdata` <= `int_rdata`; go to DONE.
- **IDLE, request & `cs`=1:**
  - `stall` = 1.
  - Latch `ext_addr` <= `addr`, `ext_wdata` <= `wdata`, `ext_we` <= `mem_wr`.
  - `ext_req` <= 1; clear the timeout counter; go to EXT.
- **EXT:**
  - `stall` = 1; counter increments each cycle.
  - `ext_ack` = 1: `ext_req` <= 0; on a read, `rdata` <= `ext_rdata`; go to DONE.
  - No ack and counter == TIMEOUT-1: `ext_req` <= 0, `bus_err` <= 1, `rdata` <= all ones; go to DONE.
- **DONE:** `stall` = 0; the CPU advances on this edge. The request still visible in this cycle is ignored, not re-issued. `bus_err` clears on exit. Go to IDLE.
- `ext_ack` outside EXT is ignored.
- `rdata` holds its value except on the loads listed above. Writes do not alter `rdata`.
- Counter width is clog2(TIMEOUT+1); it never wraps because it is cleared on EXT entry.

## Timing
- Reset values: state IDLE, `rdata` = 0, `bus_err` = 0, `ext_req` = 0, `ext_we` = 0, `ext_addr` = 0, `ext_wdata` = 0, counter = 0.
- Combinational outputs are 0 in reset: `stall`, `int_en`, `int_we`.
- Reset asserted mid-access (INT_RD or EXT) aborts the access. The next edge gives IDLE and `ext_req` = 0, with no bus error.
- Internal write: 0 stall cycles.
- Internal read: 2 stall cycles (IDLE, INT_RD), then DONE.
- External access:
  - `ext_req` rises on the edge after the request is seen.
  - If ack arrives in the k-th EXT cycle (k ≥ 1), stall lasts k+1 cycles, then DONE.
  - Ack is accepted in the same cycle `ext_req` first appears.
- Timeout: `ext_req` is high for exactly TIMEOUT cycles. An ack in the final cycle wins over the timeout, so `bus_err` = 0.
- `cs`, `addr` and `wdata` changing after IDLE have no effect on an external access in progress.

## Test plan
- Reset: assert `rst` for 2 cycles during EXT with `addr`=0x0E00 -> next cycle `ext_req`=0, `stall`=0, `rdata`=0, `bus_err`=0.
- Internal write then read: write 0xDEADBEEF to 0x0B10 (`cs`=0) -> `stall` stays 0, `int_we` pulses 1 cycle. Read 0x0B10 -> `stall`=1 for 2 cycles, then `rdata`=0xDEADBEEF in DONE.
- External read, ack after 3 cycles: `addr`=0x0E00, `ext_rdata`=0x12345678 -> `ext_req` high 3 cycles, `ext_addr`=0x0E00, `ext_we`=0, `stall` 4 cycles, `rdata`=0x12345678, `bus_err`=0.
- External write, immediate ack: `addr`=0xFFFF0E00, `wdata`=0xA5A5A5A5, ack in first EXT cycle -> `ext_req` 1 cycle, `ext_we`=1, `ext_wdata`=0xA5A5A5A5, `stall` 2 cycles, `rdata` unchanged.
- Timeout, TIMEOUT=4: external read with no ack -> `ext_req` high exactly 4 cycles, then DONE with `bus_err`=1 for 1 cycle and `rdata`=0xFFFFFFFF. Repeat with ack in the 4th cycle -> `bus_err`=0.
- Back-to-back and priority: hold `mem_rd` through DONE -> exactly one access issued. `mem_rd`=`mem_wr`=1 at 0x0A00 -> treated as internal write (`int_we`=1, no stall).

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl -- memory-stage bus controller.
// Steers CPU accesses to the on-chip synchronous RAM (cs=0) or to external
// memory over a req/ack handshake (cs=1), stalling the CPU until the access
// completes. An external access without ack aborts after TIMEOUT cycles and
// flags a bus error.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_cs, i_mem_rd, i_mem_wr         decoder select and CPU request
//   i_addr, i_wdata                  CPU address / write data
//   o_rdata, o_stall, o_bus_err      CPU response
//   o_int_en/we/addr/wdata, i_int_rdata   internal RAM port (1-cycle read)
//   o_ext_req/we/addr/wdata, i_ext_ack, i_ext_rdata   external handshake
module mem_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall,
  output logic              o_bus_err,
  output logic              o_int_en,
  output logic              o_int_we,
  output logic [ADDR_W-1:0] o_int_addr,
  output logic [DATA_W-1:0] o_int_wdata,
  input  logic [DATA_W-1:0] i_int_rdata,
  output logic              o_ext_req,
  output logic              o_ext_we,
  output logic [ADDR_W-1:0] o_ext_addr,
  output logic [DATA_W-1:0] o_ext_wdata,
  input  logic              i_ext_ack,
  input  logic [DATA_W-1:0] i_ext_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_INT_RD, S_EXT, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req, w_tmo;

  assign w_req       = i_mem_rd | i_mem_wr;
  assign w_tmo       = (r_cnt == CNT_LAST);
  assign o_int_addr  = i_addr;
  assign o_int_wdata = i_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_stall  = 1'b0;
    o_int_en = 1'b0;
    o_int_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (i_cs) begin
            o_stall = 1'b1;
            w_next  = S_EXT;
          end else if (i_mem_wr) begin
            // internal write completes in this cycle, no stall
            o_int_en = 1'b1;
            o_int_we = 1'b1;
          end else begin
            o_int_en = 1'b1;
            o_stall  = 1'b1;
            w_next   = S_INT_RD;
          end
        end
      end
      S_INT_RD: begin
        o_stall = 1'b1;
        w_next  = S_DONE;
      end
      S_EXT: begin
        o_stall = 1'b1;
        if (i_ext_ack || w_tmo) w_next = S_DONE;
      end
      // CPU advances on this edge; the still-visible request is dropped
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (i_rst) begin
      o_stall  = 1'b0;
      o_int_en = 1'b0;
      o_int_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata     <= '0;
      o_bus_err   <= 1'b0;
      o_ext_req   <= 1'b0;
      o_ext_we    <= 1'b0;
      o_ext_addr  <= '0;
      o_ext_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && i_cs) begin
            o_ext_addr  <= i_addr;
            o_ext_wdata <= i_wdata;
            o_ext_we    <= i_mem_wr;
            o_ext_req   <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_INT_RD: o_rdata <= i_int_rdata;
        S_EXT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // ack in the final cycle wins over the timeout
          if (i_ext_ack) begin
            o_ext_req <= 1'b0;
            if (!o_ext_we) o_rdata <= i_ext_rdata;
          end else if (w_tmo) begin
            o_ext_req <= 1'b0;
            o_bus_err <= 1'b1;
            o_rdata   <= '1;
          end
        end
        S_DONE:  o_bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
